seg_scan_disp: RTL and testbench
================================

# seg_scan_disp

Four-digit multiplexed 7-segment display driver that sits downstream of the seconds counter. It latches packed BCD digits on a load strobe. It copies them to the display register only at scan-frame boundaries, so the display never tears. It scans one digit at a time with an anti-ghosting blank interval and drives active-low segment and digit-select pins on a common-anode module.

## Interface
- `SCAN_DIV`, 24000: clk cycles per digit slot (1 ms at 24 MHz). Legal range ≥ 2.
- `BLANK`, 24: cycles at the start of each slot with all digits off. Legal range 0 ≤ BLANK < SCAN_DIV.
- `DP_MASK`, 4'b0000: bit i set lights the decimal point on digit i.
- `clk` in 1: system clock.
- `res` in 1: reset. Synchronous, active-high.
- `d_num` in 16: four BCD digits; [3:0] is digit 0 (ones, the seconds counter value), [15:12] is digit 3.
- `d_load` in 1: capture `d_num` into the shadow register this cycle.
- `seg` out 8: {dp,g,f,e,d,c,b,a}, active-low.
- `dig_sel` out 4: digit enables, active-low, at most one low.
- `bad_bcd` out 1: sticky flag; a loaded nibble was greater than 9.

## Operation
- **Shadow register:** on `d_load`, shadow <= `d_num`. If any nibble of `d_num` is greater than 9, `bad_bcd` <= 1. `bad_bcd` clears only on `res`.
- **Divider:** `div_cnt` counts 0..SCAN_DIV-1 and wraps. Width is clog2(SCAN_DIV).
- **Digit index:** `idx` (2 bits) increments when `div_cnt`==SCAN_DIV-1, wrapping 3 to 0.
- **Frame boundary:** the cycle where `div_cnt`==SCAN_DIV-1 and `idx`==3. At this cycle, disp <= shadow.
  - If `d_load` is asserted in the same cycle, disp takes the *old* shadow. The new value appears one frame later.
- **Decode of the selected nibble disp[idx]:**
  - 0 → 7'h40, 1 → 79, 2 → 24, 3 → 30, 4 → 19, 5 → 12, 6 → 02, 7 → 78, 8 → 00, 9 → 10.
  - 10–15 → 7'h3F ("-", segment g only).
- **Decimal point:** dp bit = ~DP_MASK[idx].
- **Blanking:** while `div_cnt` < BLANK, `dig_sel`=4'b1111 and `seg`=8'hFF. Otherwise `dig_sel`=~(4'b0001<<idx).
- **Reset mid-operation:** all state returns to reset values on the next clk edge. This covers the divider, index, shadow, disp and flag. There is no partial frame completion.

## Timing
- **Reset values:**
  - Outputs: `seg`=8'hFF, `dig_sel`=4'b1111, `bad_bcd`=0.
  - Internal: `div_cnt`=0, `idx`=0, shadow=0, disp=0.
- All outputs are registered. `seg` and `dig_sel` at edge n+1 reflect `div_cnt`, `idx` and disp of cycle n.
- **First lit digit:** digit 0 goes low on `dig_sel` BLANK+1 cycles after `res` deasserts. With BLANK=0 it is 1 cycle.
- **Frame period:** 4·SCAN_DIV cycles. Each digit is lit SCAN_DIV-BLANK cycles per frame.
- **Load-to-display latency:** between 1 and 4·SCAN_DIV cycles (next frame boundary), plus 1 output register cycle. A load in the boundary cycle costs one extra frame.
- **Flag timing:** `bad_bcd` rises 1 cycle after the offending `d_load`.
- **Repeated loads:** back-to-back `d_load` every cycle is legal. The last value before the boundary wins.

## Configuration
- `SEG_LZB_EN` defined: leading-zero blanking is on.
  - Digit i (i=3..1) outputs `seg`=8'hFF except the dp bit, which still follows DP_MASK.
  - This applies when disp[i] and all higher disp nibbles are 0.
  - Digit 0 is never blanked.
  - `dig_sel` timing is unchanged.
- `SEG_LZB_EN` undefined: all four digits always decode normally. Zeros display as 8'hC0, with dp off.

## Test plan
Parameters for every scenario unless stated: SCAN_DIV=8, BLANK=1, DP_MASK=0.
- **Reset:** hold `res`=1 for 3 cycles, then release.
  - Required: `seg`=8'hFF and `dig_sel`=4'hF until the edge after cycle 1.
  - Then `dig_sel`=4'b1110 for 7 cycles, 4'hF for 1 cycle, then 4'b1101.
- **Load/tearing:** load `d_num`=16'h1857 mid-frame.
  - Required: the current frame still shows 0s.
  - After the next boundary: digit0 `seg`=8'hF8, digit1 8'h92, digit2 8'h80, digit3 8'hF9.
- **Simultaneous load and boundary:** assert `d_load` exactly in the boundary cycle.
  - Required: disp is unchanged for that frame; the new value appears at the following boundary.
- **Invalid BCD:** load 16'h00A3.
  - Required: `bad_bcd`=1 one cycle later; digit1 shows 8'hBF.
  - A subsequent load of 16'h0000 leaves `bad_bcd`=1 until `res`.
- **Leading-zero blanking and DP:** DP_MASK=4'b0010, load 16'h0005.
  - With `SEG_LZB_EN`: digit3/2 8'hFF, digit1 8'h7F, digit0 8'h92.
  - Without `SEG_LZB_EN`: digit3/2 8'hC0, digit1 8'h40.
- **Mid-scan reset:** assert `res` for 1 cycle while `idx`=2 is lit.
  - Required: the next edge gives `seg`=8'hFF, `dig_sel`=4'hF, `bad_bcd`=0, and display 0s after the subsequent frame.

Source files
------------

// File: rtl/seg_scan_disp.sv
// Four-digit multiplexed common-anode 7-segment driver with tear-free frame updates.
// Define SEG_LZB_EN to blank leading zeros on digits 3..1 (decimal points still follow DP_MASK).
module seg_scan_disp #(
    parameter int         SCAN_DIV = 24000,
    parameter int         BLANK    = 24,
    parameter logic [3:0] DP_MASK  = 4'b0000
) (
    input  logic        clk,
    input  logic        res,
    input  logic [15:0] d_num,
    input  logic        d_load,
    output logic [7:0]  seg,
    output logic [3:0]  dig_sel,
    output logic        bad_bcd
);

    localparam int            CW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK);

    logic [CW-1:0] div_cnt;
    logic [1:0]    idx;
    logic [15:0]   shadow;
    logic [15:0]   disp;

    logic          slot_end;
    logic          frame_end;
    logic          load_bad;
    logic          in_blank;
    logic          lz_blank;
    logic [3:0]    nib;
    logic [6:0]    glyph;
    logic [7:0]    seg_next;
    logic [3:0]    dig_sel_next;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd0:    decode = 7'h40;
            4'd1:    decode = 7'h79;
            4'd2:    decode = 7'h24;
            4'd3:    decode = 7'h30;
            4'd4:    decode = 7'h19;
            4'd5:    decode = 7'h12;
            4'd6:    decode = 7'h02;
            4'd7:    decode = 7'h78;
            4'd8:    decode = 7'h00;
            4'd9:    decode = 7'h10;
            default: decode = 7'h3F;
        endcase
    endfunction

    assign slot_end  = (div_cnt == DIV_LAST);
    assign frame_end = slot_end && (idx == 2'd3);

    always_comb begin
        load_bad = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (d_num[k*4 +: 4] > 4'd9) begin
                load_bad = 1'b1;
            end
        end
    end

    assign nib   = disp[{idx, 2'b00} +: 4];
    assign glyph = decode(nib);

    // A digit is a leading zero when it and every more significant digit are zero.
    always_comb begin
        lz_blank = 1'b0;
`ifdef SEG_LZB_EN
        case (idx)
            2'd3:    lz_blank = (disp[15:12] == 4'd0);
            2'd2:    lz_blank = (disp[15:8] == 8'd0);
            2'd1:    lz_blank = (disp[15:4] == 12'd0);
            default: lz_blank = 1'b0;
        endcase
`endif
    end

    assign in_blank = (div_cnt < BLANK_END);

    always_comb begin
        seg_next     = 8'hFF;
        dig_sel_next = 4'b1111;
        if (!in_blank) begin
            dig_sel_next = ~(4'b0001 << idx);
            seg_next     = {~DP_MASK[idx], (lz_blank ? 7'h7F : glyph)};
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            div_cnt <= '0;
            idx     <= 2'd0;
        end else begin
            if (slot_end) begin
                div_cnt <= '0;
                idx     <= idx + 2'd1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    // disp copies the pre-load shadow, so a load in the boundary cycle waits a full frame.
    always_ff @(posedge clk) begin
        if (res) begin
            shadow  <= 16'h0000;
            disp    <= 16'h0000;
            bad_bcd <= 1'b0;
        end else begin
            if (frame_end) begin
                disp <= shadow;
            end
            if (d_load) begin
                shadow <= d_num;
                if (load_bad) begin
                    bad_bcd <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            seg     <= 8'hFF;
            dig_sel <= 4'b1111;
        end else begin
            seg     <= seg_next;
            dig_sel <= dig_sel_next;
        end
    end

endmodule

// File: tb/tb_seg_scan_disp.sv
// Self-checking bench for seg_scan_disp: directed scenarios plus randomized traffic
// against a cycle-count based reference model; SEG_LZB_EN selects the blanking expectations.
module tb_seg_scan_disp;

    localparam int SD    = 8;
    localparam int BL    = 1;
    localparam int FRAME = 4 * SD;

    localparam logic [7:0] NEW_SEG [4] = '{8'hF8, 8'h92, 8'h80, 8'hF9};
    localparam logic [7:0] B2B_SEG [4] = '{8'hC0, 8'h82, 8'h99, 8'hA4};
    localparam logic [7:0] BAD_SEG [4] = '{8'hB0, 8'hBF, 8'hC0, 8'hC0};
`ifdef SEG_LZB_EN
    localparam logic [7:0] LZ_SEG    [4] = '{8'h92, 8'hFF, 8'hFF, 8'hFF};
    localparam logic [7:0] LZ_SEG_DP [4] = '{8'h92, 8'h7F, 8'hFF, 8'hFF};
`else
    localparam logic [7:0] LZ_SEG    [4] = '{8'h92, 8'hC0, 8'hC0, 8'hC0};
    localparam logic [7:0] LZ_SEG_DP [4] = '{8'h92, 8'h40, 8'hC0, 8'hC0};
`endif
    localparam logic [3:0] RST_DIG [10] = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hE,
                                            4'hE, 4'hE, 4'hE, 4'hF, 4'hD};

    logic        clk = 1'b0;
    logic        res = 1'b1;
    logic [15:0] d_num = 16'h0000;
    logic        d_load = 1'b0;
    logic [7:0]  seg, seg_dp;
    logic [3:0]  dig_sel, dig_sel_dp;
    logic        bad_bcd, bad_bcd_dp;

    int checks = 0;
    int failures = 0;

    int          m_cyc;
    logic [15:0] m_shadow, m_disp;
    logic        m_bad;
    logic [7:0]  e_seg, e_seg_dp;
    logic [3:0]  e_dig;
    logic        e_bad;

    always #5 clk = ~clk;

    seg_scan_disp #(.SCAN_DIV(SD), .BLANK(BL), .DP_MASK(4'b0000)) dut (
        .clk(clk), .res(res), .d_num(d_num), .d_load(d_load),
        .seg(seg), .dig_sel(dig_sel), .bad_bcd(bad_bcd)
    );

    seg_scan_disp #(.SCAN_DIV(SD), .BLANK(BL), .DP_MASK(4'b0010)) dut_dp (
        .clk(clk), .res(res), .d_num(d_num), .d_load(d_load),
        .seg(seg_dp), .dig_sel(dig_sel_dp), .bad_bcd(bad_bcd_dp)
    );

    function automatic logic [6:0] font(input logic [3:0] v);
        case (v)
            4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
            4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
            4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
            4'd9: return 7'h10;  default: return 7'h3F;
        endcase
    endfunction

    function automatic logic [7:0] model_seg(input logic [3:0] mask, input logic [15:0] dv, input int digit);
        logic lz;
        lz = 1'b0;
`ifdef SEG_LZB_EN
        if (digit > 0 && (dv >> (digit * 4)) == 16'h0000) lz = 1'b1;
`endif
        return lz ? {~mask[digit], 7'h7F} : {~mask[digit], font(dv[digit*4 +: 4])};
    endfunction

    function automatic int lit_digit(input logic [3:0] ds);
        case (ds)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return -1;
        endcase
    endfunction

    // Model state advances from the absolute cycle count since reset, then the clock moves on.
    task automatic tick();
        int pos, slot;
        if (res) begin
            e_seg = 8'hFF; e_seg_dp = 8'hFF; e_dig = 4'hF; e_bad = 1'b0;
            m_cyc = 0; m_shadow = 16'h0; m_disp = 16'h0; m_bad = 1'b0;
        end else begin
            pos  = m_cyc % SD;
            slot = (m_cyc / SD) % 4;
            if (pos < BL) begin
                e_seg = 8'hFF; e_seg_dp = 8'hFF; e_dig = 4'hF;
            end else begin
                e_dig    = ~(4'b0001 << slot);
                e_seg    = model_seg(4'b0000, m_disp, slot);
                e_seg_dp = model_seg(4'b0010, m_disp, slot);
            end
            if (pos == SD - 1 && slot == 3) m_disp = m_shadow;
            if (d_load) begin
                m_shadow = d_num;
                for (int k = 0; k < 4; k++) if (d_num[k*4 +: 4] > 4'd9) m_bad = 1'b1;
            end
            e_bad = m_bad;
            m_cyc++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        res = 1'b1;
        repeat (3) begin
            tick();
            checks++;
            if ({seg, dig_sel, bad_bcd} !== {8'hFF, 4'hF, 1'b0}) begin
                failures++;
                $display("[TB] FAIL reset_hold seg=%h dig=%h bad=%b want FF F 0", seg, dig_sel, bad_bcd);
            end
        end
        res = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (dig_sel !== RST_DIG[i] || seg !== ((RST_DIG[i] == 4'hF) ? 8'hFF : 8'hC0)) begin
                failures++;
                $display("[TB] FAIL reset_seq[%0d] seg=%h dig=%h want dig=%h", i, seg, dig_sel, RST_DIG[i]);
            end
        end
    endtask

    task automatic test_load_tearing();
        int d;
        while (m_cyc % FRAME != 12) tick();
        d_num = 16'h1857; d_load = 1'b1;
        tick();
        d_load = 1'b0;
        while (m_cyc % FRAME != 0) begin
            tick();
            d = lit_digit(dig_sel);
            if (d >= 0) begin
                checks++;
                if (seg !== 8'hC0) begin
                    failures++;
                    $display("[TB] FAIL tearing_old digit%0d seg=%h want C0", d, seg);
                end
            end
        end
        repeat (FRAME) begin
            tick();
            d = lit_digit(dig_sel);
            if (d >= 0) begin
                checks++;
                if (seg !== NEW_SEG[d]) begin
                    failures++;
                    $display("[TB] FAIL tearing_new digit%0d seg=%h want %h", d, seg, NEW_SEG[d]);
                end
            end
        end
    endtask

    task automatic test_boundary_load();
        int d;
        while (m_cyc % FRAME != FRAME - 1) tick();
        d_num = 16'h2460; d_load = 1'b1;
        tick();
        d_load = 1'b0;
        repeat (FRAME) begin
            tick();
            d = lit_digit(dig_sel);
            if (d >= 0) begin
                checks++;
                if (seg !== NEW_SEG[d]) begin
                    failures++;
                    $display("[TB] FAIL boundary_hold digit%0d seg=%h want %h", d, seg, NEW_SEG[d]);
                end
            end
        end
        repeat (FRAME) begin
            tick();
            d = lit_digit(dig_sel);
            if (d >= 0) begin
                checks++;
                if (seg !== B2B_SEG[d]) begin
                    failures++;
                    $display("[TB] FAIL boundary_new digit%0d seg=%h want %h", d, seg, B2B_SEG[d]);
                end
            end
        end
    endtask

    task automatic test_invalid_bcd();
        int d;
        checks++;
        if (bad_bcd !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bad_bcd_pre got=%b want 0", bad_bcd);
        end
        d_num = 16'h00A3; d_load = 1'b1;
        tick();
        d_load = 1'b0;
        checks++;
        if (bad_bcd !== 1'b1 || bad_bcd_dp !== 1'b1) begin
            failures++;
            $display("[TB] FAIL bad_bcd_rise got=%b/%b want 1", bad_bcd, bad_bcd_dp);
        end
        while (m_cyc % FRAME != 0) tick();
        repeat (FRAME) begin
            tick();
            d = lit_digit(dig_sel);
            if (d >= 0) begin
                checks++;
                if (seg !== BAD_SEG[d]) begin
                    failures++;
                    $display("[TB] FAIL bad_bcd_show digit%0d seg=%h want %h", d, seg, BAD_SEG[d]);
                end
            end
        end
        d_num = 16'h0000; d_load = 1'b1;
        tick();
        d_load = 1'b0;
        repeat (2 * FRAME) begin
            tick();
            checks++;
            if (bad_bcd !== 1'b1) begin
                failures++;
                $display("[TB] FAIL bad_bcd_sticky got=%b want 1", bad_bcd);
            end
        end
    endtask

    task automatic test_lzb_dp();
        int d, e;
        d_num = 16'h0005; d_load = 1'b1;
        tick();
        d_load = 1'b0;
        while (m_cyc % FRAME != 0) tick();
        repeat (FRAME) begin
            tick();
            d = lit_digit(dig_sel);
            e = lit_digit(dig_sel_dp);
            if (d >= 0) begin
                checks++;
                if (seg !== LZ_SEG[d]) begin
                    failures++;
                    $display("[TB] FAIL lzb digit%0d seg=%h want %h", d, seg, LZ_SEG[d]);
                end
            end
            if (e >= 0) begin
                checks++;
                if (seg_dp !== LZ_SEG_DP[e]) begin
                    failures++;
                    $display("[TB] FAIL lzb_dp digit%0d seg=%h want %h", e, seg_dp, LZ_SEG_DP[e]);
                end
            end
        end
    endtask

    task automatic test_mid_scan_reset();
        int d;
        bit found;
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            tick();
            if (dig_sel === 4'b1011) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("[TB] FAIL midreset_wait dig=%h never reached 1011", dig_sel);
        end
        res = 1'b1;
        tick();
        res = 1'b0;
        checks++;
        if ({seg, dig_sel, bad_bcd, seg_dp, dig_sel_dp, bad_bcd_dp} !== {8'hFF, 4'hF, 1'b0, 8'hFF, 4'hF, 1'b0}) begin
            failures++;
            $display("[TB] FAIL midreset_out seg=%h dig=%h bad=%b want FF F 0", seg, dig_sel, bad_bcd);
        end
        repeat (2 * FRAME) begin
            tick();
            d = lit_digit(dig_sel);
            if (d >= 0) begin
                checks++;
                if (seg !== 8'hC0) begin
                    failures++;
                    $display("[TB] FAIL midreset_zero digit%0d seg=%h want C0", d, seg);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        while (m_cyc % FRAME != FRAME - 6) tick();
        for (int i = 0; i < 10 + 2 * FRAME; i++) begin
            d_load = (i < 10);
            for (int k = 0; k < 4; k++) d_num[k*4 +: 4] = 4'($urandom_range(0, 9));
            tick();
            checks++;
            if ({seg, dig_sel, bad_bcd, seg_dp} !== {e_seg, e_dig, e_bad, e_seg_dp}) begin
                failures++;
                $display("[TB] FAIL back_to_back cyc=%0d seg=%h dig=%h bad=%b dp=%h want %h %h %b %h",
                         m_cyc, seg, dig_sel, bad_bcd, seg_dp, e_seg, e_dig, e_bad, e_seg_dp);
            end
        end
        d_load = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            res    = ($urandom_range(0, 499) == 0);
            d_load = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 5) == 0) d_num = 16'($urandom);
            else for (int k = 0; k < 4; k++) d_num[k*4 +: 4] = 4'($urandom_range(0, 9));
            tick();
            checks++;
            if ({seg, dig_sel, bad_bcd, seg_dp, dig_sel_dp, bad_bcd_dp} !==
                {e_seg, e_dig, e_bad, e_seg_dp, e_dig, e_bad}) begin
                failures++;
                $display("[TB] FAIL random cyc=%0d seg=%h dig=%h bad=%b dp=%h want %h %h %b %h",
                         m_cyc, seg, dig_sel, bad_bcd, seg_dp, e_seg, e_dig, e_bad, e_seg_dp);
            end
        end
        res = 1'b0;
        d_load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_tearing();
        test_boundary_load();
        test_invalid_bcd();
        test_lzb_dp();
        test_mid_scan_reset();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
